// File: rtl/bpsk_pkg.sv
// ============================================================================
//  Module   : bpsk_pkg
//  Purpose  : Shared state encoding and default timing constants for the
//             BPSK transmit scheduler.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package bpsk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int         CLK_HZ          = 48000000;
    localparam int         CAR_HALF_DEF    = 3000000;
    localparam int         CYC_PER_BIT_DEF = 8;
    localparam logic [7:0] PREAMBLE_DEF    = 8'b10101010;

    // Counter width that stays legal when a count range degenerates to one value.
    function automatic int ctr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bpsk_carrier_gen.sv
// ============================================================================
//  Module   : bpsk_carrier_gen
//  Purpose  : Square-wave carrier with per-cycle and per-bit tick strobes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bpsk_carrier_gen
    import bpsk_pkg::*;
#(
    parameter int CAR_HALF    = CAR_HALF_DEF,
    parameter int CYC_PER_BIT = CYC_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    output logic carrier_o,
    output logic bit_tick_o
);

    localparam int            HW        = ctr_w(CAR_HALF);
    localparam int            CW        = ctr_w(CYC_PER_BIT);
    localparam logic [HW-1:0] HALF_LAST = HW'(CAR_HALF - 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(CYC_PER_BIT - 1);

    logic [HW-1:0] half_q, half_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          carrier_q, carrier_d;
    logic          half_wrap, cyc_tick;

    // Ticks are decoded in the cycle before the rising edge so that logic
    // consuming them updates on the very edge where the carrier goes high.
    always_comb begin
        half_wrap  = enable_i && (half_q == HALF_LAST);
        cyc_tick   = half_wrap && !carrier_q;
        bit_tick_o = cyc_tick && (cyc_q == CYC_LAST);
        half_d     = half_wrap ? '0 : half_q + HW'(1);
        carrier_d  = half_wrap ? ~carrier_q : carrier_q;
        cyc_d      = cyc_q;
        if (cyc_tick) begin
            cyc_d = bit_tick_o ? '0 : cyc_q + CW'(1);
        end
        if (!enable_i) begin
            half_d    = '0;
            cyc_d     = '0;
            carrier_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            half_q    <= '0;
            cyc_q     <= '0;
            carrier_q <= 1'b0;
        end else begin
            half_q    <= half_d;
            cyc_q     <= cyc_d;
            carrier_q <= carrier_d;
        end
    end

    assign carrier_o = carrier_q;

endmodule

`default_nettype wire

// File: rtl/bpsk_tx_sched.sv
// ============================================================================
//  Module   : bpsk_tx_sched
//  Purpose  : Byte-framing BPSK transmit scheduler; bit changes land on carrier
//             rising edges. Define BPSK_DIFF_ENC_EN for differential encoding.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bpsk_tx_sched
    import bpsk_pkg::*;
#(
    parameter int         CAR_HALF    = CAR_HALF_DEF,
    parameter int         CYC_PER_BIT = CYC_PER_BIT_DEF,
    parameter logic [7:0] PREAMBLE    = PREAMBLE_DEF,
    parameter int         PRE_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       carrier,
    output logic       tx_bit,
    output logic       bpsk_mod,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] PRE_LAST = 3'(PRE_LEN - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       tx_q, tx_d;
    logic       fd_q, fd_d;
    logic       ready_q;
    logic       bit_tick;
    logic       emit, src_bit;
`ifdef BPSK_DIFF_ENC_EN
    logic       dstate_q, dstate_d;
`endif

    bpsk_carrier_gen #(
        .CAR_HALF    (CAR_HALF),
        .CYC_PER_BIT (CYC_PER_BIT)
    ) u_carrier (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (enable),
        .carrier_o  (carrier),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        fd_d        = 1'b0;
        emit        = 1'b0;
        src_bit     = 1'b0;
`ifdef BPSK_DIFF_ENC_EN
        dstate_d    = dstate_q;
`endif
        // ready_q is low whenever hold_full_q is set, so accept and load never coincide.
        if (byte_valid && ready_q) begin
            hold_d      = byte_data;
            hold_full_d = 1'b1;
        end
        if (bit_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        state_d = PRE;
                        idx_d   = 3'd0;
                        src_bit = PREAMBLE[7];
                        shift_d = {PREAMBLE[6:0], 1'b0};
                        emit    = 1'b1;
                    end
                end
                PRE, DATA: begin
                    if ((state_q == PRE) ? (idx_q == PRE_LAST) : (idx_q == 3'd7)) begin
                        if (hold_full_q) begin
                            state_d     = DATA;
                            idx_d       = 3'd0;
                            src_bit     = hold_q[7];
                            shift_d     = {hold_q[6:0], 1'b0};
                            hold_full_d = 1'b0;
                            emit        = 1'b1;
                        end else begin
                            state_d = IDLE;
                            idx_d   = 3'd0;
                            tx_d    = 1'b0;
                            fd_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        src_bit = shift_q[7];
                        shift_d = {shift_q[6:0], 1'b0};
                        emit    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (emit) begin
`ifdef BPSK_DIFF_ENC_EN
            dstate_d = (state_q == IDLE) ? 1'b0 : (dstate_q ^ ~src_bit);
            tx_d     = dstate_d;
`else
            tx_d     = src_bit;
`endif
        end
        if (!enable) begin
            state_d     = IDLE;
            idx_d       = 3'd0;
            shift_d     = 8'd0;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            fd_d        = 1'b0;
`ifdef BPSK_DIFF_ENC_EN
            dstate_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b0;
            fd_q        <= 1'b0;
            ready_q     <= 1'b0;
`ifdef BPSK_DIFF_ENC_EN
            dstate_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            fd_q        <= fd_d;
            ready_q     <= ~hold_full_d;
`ifdef BPSK_DIFF_ENC_EN
            dstate_q    <= dstate_d;
`endif
        end
    end

    assign byte_ready = ready_q;
    assign tx_bit     = tx_q;
    assign frame_done = fd_q;
    assign busy       = (state_q != IDLE);
    assign bpsk_mod   = busy & (tx_q ? carrier : ~carrier);

endmodule

`default_nettype wire

// File: tb/tb_bpsk_tx_sched.sv
// ============================================================================
//  Module   : tb_bpsk_tx_sched
//  Purpose  : Self-checking bench for bpsk_tx_sched against a bit-queue model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bpsk_tx_sched;

    localparam int         CH   = 2;
    localparam int         CPB  = 2;
    localparam int         PL   = 4;
    localparam logic [7:0] PRE  = 8'b10101010;
    localparam int         BITP = 2 * CH * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic       byte_ready, carrier, tx_bit, bpsk_mod, busy, frame_done;

    always #5 clk = ~clk;

    bpsk_tx_sched #(
        .CAR_HALF    (CH),
        .CYC_PER_BIT (CPB),
        .PREAMBLE    (PRE),
        .PRE_LEN     (PL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .carrier    (carrier),
        .tx_bit     (tx_bit),
        .bpsk_mod   (bpsk_mod),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: time since counters last cleared, pending bytes, bits on air.
    int         kc = 0;
    bit         rdy_ok = 0, active = 0, tx_m = 0, fd_m = 0, bnd_m = 0, d_m = 0;
    logic [7:0] byteq[$];
    bit         bitq[$];
    bit         obs[$];
    int         fd_cnt = 0;

    typedef struct {
        logic [7:0]  data;
        logic [11:0] bits;
    } vec_t;
    vec_t tbl[3];

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic emit(input bit first);
        bit s;
        s = bitq.pop_front();
        if (first) d_m = 1'b0;
`ifdef BPSK_DIFF_ENC_EN
        if (!first) d_m = d_m ^ ~s;
        tx_m = d_m;
`else
        tx_m = s;
`endif
        bnd_m = 1'b1;
    endtask

    task automatic model_edge();
        bit         acc;
        logic [7:0] b;
        logic [7:0] pre_v;
        pre_v = PRE;
        fd_m  = 1'b0;
        bnd_m = 1'b0;
        if (rst) begin
            kc = 0; rdy_ok = 0; active = 0; tx_m = 0; d_m = 0;
            byteq.delete(); bitq.delete();
            return;
        end
        if (!enable) begin
            kc = 0; rdy_ok = 1; active = 0; tx_m = 0; d_m = 0;
            byteq.delete(); bitq.delete();
            return;
        end
        acc = byte_valid && rdy_ok && (byteq.size() == 0);
        kc++;
        if (kc % BITP == BITP - CH) begin
            if (!active) begin
                if (byteq.size() != 0) begin
                    active = 1;
                    for (int i = 0; i < PL; i++) bitq.push_back(pre_v[7-i]);
                    emit(1'b1);
                end
            end else if (bitq.size() != 0) begin
                emit(1'b0);
            end else if (byteq.size() != 0) begin
                b = byteq.pop_front();
                for (int i = 0; i < 8; i++) bitq.push_back(b[7-i]);
                emit(1'b0);
            end else begin
                active = 0; tx_m = 0; fd_m = 1;
            end
        end
        if (acc) byteq.push_back(byte_data);
        rdy_ok = 1;
    endtask

    task automatic check_outputs();
        bit car_e;
        car_e = ((kc / CH) % 2) == 1;
        chk1("carrier",    carrier,    car_e);
        chk1("tx_bit",     tx_bit,     tx_m);
        chk1("busy",       busy,       active);
        chk1("bpsk_mod",   bpsk_mod,   active && (tx_m ? car_e : !car_e));
        chk1("byte_ready", byte_ready, rdy_ok && (byteq.size() == 0));
        chk1("frame_done", frame_done, fd_m);
    endtask

    task automatic step(input bit r, input bit e, input bit v, input logic [7:0] d);
        rst = r; enable = e; byte_valid = v; byte_data = d;
        model_edge();
        @(negedge clk);
        check_outputs();
        if (bnd_m && busy) obs.push_back(tx_bit);
        if (frame_done) fd_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic offer(input logic [7:0] b);
        int g;
        g = 0;
        while (!(rdy_ok && byteq.size() == 0) && g < 200) begin
            step(1'b0, 1'b1, 1'b0, 8'd0);
            g++;
        end
        chk1("offer_wait", g < 200, 1'b1);
        step(1'b0, 1'b1, 1'b1, b);
    endtask

    task automatic drain(input int max);
        int g;
        g = 0;
        while ((active || byteq.size() != 0) && g < max) begin
            step(1'b0, 1'b1, 1'b0, 8'd0);
            g++;
        end
        chk1("drain_wait", g < max, 1'b1);
    endtask

    function automatic int pack_obs();
        int p;
        p = 0;
        foreach (obs[j]) p = (p << 1) | int'(obs[j]);
        return p;
    endfunction

    initial begin
        int g;
        tbl[0] = '{8'hC5, 12'b1010_1100_0101};
        tbl[1] = '{8'h3C, 12'b1010_0011_1100};
        tbl[2] = '{8'h81, 12'b1010_1000_0001};

        // Reset state, then quiet carrier with no data.
        repeat (3) step(1'b1, 1'b1, 1'b0, 8'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", byte_ready, 1'b0);
        chk1("rst_carrier", carrier, 1'b0);
        idle(24);

`ifndef BPSK_DIFF_ENC_EN
        for (int i = 0; i < 3; i++) begin
            obs.delete(); fd_cnt = 0;
            offer(tbl[i].data);
            drain(300);
            idle(2);
            chkv("frame_len", obs.size(), 12);
            chkv("frame_bits", pack_obs(), int'(tbl[i].bits));
            chkv("frame_done_cnt", fd_cnt, 1);
        end

        // Back-to-back bytes: second offered while the first is in flight.
        obs.delete(); fd_cnt = 0;
        offer(8'hFF);
        offer(8'h00);
        chk1("b2b_busy", busy, 1'b1);
        drain(400);
        chkv("b2b_len", obs.size(), 20);
        chkv("b2b_bits", pack_obs(), 20'b1010_11111111_00000000);
        chkv("b2b_done_cnt", fd_cnt, 1);
`endif

        // Abort mid-DATA.
        obs.delete(); fd_cnt = 0;
        offer(8'h96);
        g = 0;
        while (obs.size() < 7 && g < 300) begin
            step(1'b0, 1'b1, 1'b0, 8'd0);
            g++;
        end
        chk1("abort_reach_data", g < 300, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_carrier", carrier, 1'b0);
        chk1("abort_ready", byte_ready, 1'b1);
        idle(3);
        chkv("abort_no_done", fd_cnt, 0);
        obs.delete();
        offer(8'h5A);
        drain(300);
        chkv("reenable_len", obs.size(), 12);
`ifndef BPSK_DIFF_ENC_EN
        chkv("reenable_bits", pack_obs(), 12'b1010_0101_1010);
`endif

        // Reset during PRE with byte_valid held high.
        offer(8'h33);
        g = 0;
        while (!busy && g < 100) begin
            step(1'b0, 1'b1, 1'b0, 8'd0);
            g++;
        end
        chk1("pre_reached", busy, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hE7);
        chk1("rstpre_busy", busy, 1'b0);
        chk1("rstpre_tx", tx_bit, 1'b0);
        chk1("rstpre_ready", byte_ready, 1'b0);
        chk1("rstpre_bpsk", bpsk_mod, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hE7);
        chk1("post_rst_ready", byte_ready, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'hE7);
        chk1("post_rst_accepted", byte_ready, 1'b0);
        obs.delete(); fd_cnt = 0;
        drain(300);
        chkv("post_rst_len", obs.size(), 12);
`ifndef BPSK_DIFF_ENC_EN
        chkv("post_rst_bits", pack_obs(), 12'b1010_1110_0111);
`endif
        chkv("post_rst_done", fd_cnt, 1);

`ifdef BPSK_DIFF_ENC_EN
        obs.delete();
        offer(8'h00);
        drain(300);
        g = 0;
        for (int j = 4; j < obs.size(); j++) if (obs[j] != obs[j-1]) g++;
        chkv("diff_toggles", g, 8);
`endif

        // Randomized traffic with occasional aborts and resets.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 600) == 0, ($urandom % 300) != 0,
                 ($urandom % 4) == 0, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
